counter_sweep_ctrl: RTL and testbench

Sweep controller for the up/down binary counter datapath. It owns a WIDTH-bit up/down count register and sequences it through programmed sweeps between a lower and an upper bound. Sweeps run as sawtooth ramps or triangle ramps for a programmed number of passes, under a start/busy/done handshake. It sits between a command source (test logic or a host register block) and any consumer of the count value.

---
 rtl/counter_sweep_ctrl.sv | 136 +++++++++++++
 tb/tb_counter_sweep_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_sweep_ctrl.sv
// Sweep controller: owns an up/down count register and walks it between
// programmed bounds as sawtooth or triangle ramps for a set number of passes.
module counter_sweep_ctrl #(
    parameter int WIDTH  = 4,
    parameter int PASS_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  lo,
    input  logic [WIDTH-1:0]  hi,
    input  logic              mode,
    input  logic [PASS_W-1:0] passes,
    input  logic              abort,
    output logic [WIDTH-1:0]  bin_count,
    output logic              up_down,
    output logic              count_en,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [PASS_W-1:0] pass_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_UP   = 2'd1;
    localparam logic [1:0] ST_DOWN = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]        state_q,  state_d;
    logic [WIDTH-1:0]  bin_q,    bin_d;
    logic [PASS_W-1:0] pass_q,   pass_d;
    logic [WIDTH-1:0]  lo_q,     lo_d;
    logic [WIDTH-1:0]  hi_q,     hi_d;
    logic              mode_q,   mode_d;
    logic [PASS_W-1:0] passes_q, passes_d;
    logic              err_q,    err_d;
    logic [PASS_W-1:0] pass_inc;
    logic              last_pass;

    assign pass_inc  = pass_q + 1'b1;
    assign last_pass = (pass_inc == passes_q);

    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        pass_d   = pass_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        mode_d   = mode_q;
        passes_d = passes_q;
        err_d    = 1'b0;
        count_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if ((lo <= hi) && (passes != '0)) begin
                        lo_d     = lo;
                        hi_d     = hi;
                        mode_d   = mode;
                        passes_d = passes;
                        bin_d    = lo;
                        pass_d   = '0;
                        state_d  = ST_UP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_UP: begin
                // abort wins over both counting and pass completion
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (bin_q != hi_q) begin
                    bin_d    = bin_q + 1'b1;
                    count_en = 1'b1;
                end else if (!mode_q) begin
                    pass_d = pass_inc;
                    if (last_pass) begin
                        state_d = ST_DONE;
                    end else begin
                        bin_d = lo_q;
                    end
                end else begin
                    state_d = ST_DOWN;
                end
            end
            ST_DOWN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (bin_q != lo_q) begin
                    bin_d    = bin_q - 1'b1;
                    count_en = 1'b1;
                end else begin
                    pass_d  = pass_inc;
                    state_d = last_pass ? ST_DONE : ST_UP;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            bin_q    <= '0;
            pass_q   <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            mode_q   <= 1'b0;
            passes_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bin_q    <= bin_d;
            pass_q   <= pass_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            mode_q   <= mode_d;
            passes_q <= passes_d;
            err_q    <= err_d;
        end
    end

    assign bin_count = bin_q;
    assign pass_cnt  = pass_q;
    assign up_down   = (state_q != ST_DOWN);
    assign busy      = (state_q == ST_UP) || (state_q == ST_DOWN);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Self-checking bench for counter_sweep_ctrl: directed and random sweeps
// compared cycle by cycle against a sequence model built from the sweep rules.
module tb_counter_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] lo = '0;
    logic [3:0] hi = '0;
    logic       mode = 1'b0;
    logic [3:0] passes = '0;
    logic       abort = 1'b0;
    logic [3:0] bin_count;
    logic       up_down;
    logic       count_en;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] pass_cnt;

    int checks = 0;
    int errors = 0;
    int exp_bin = 0;
    int exp_pc  = 0;

    typedef struct {
        int bin;
        int ud;
        int ce;
        int busy;
        int done;
        int pc;
    } exp_t;

    exp_t model_q[$];

    counter_sweep_ctrl #(.WIDTH(4), .PASS_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .lo(lo), .hi(hi), .mode(mode),
        .passes(passes), .abort(abort), .bin_count(bin_count), .up_down(up_down),
        .count_en(count_en), .busy(busy), .done(done), .err(err), .pass_cnt(pass_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(int b, int u, int c, int bz, int d, int p);
        exp_t e;
        e.bin = b; e.ud = u; e.ce = c; e.busy = bz; e.done = d; e.pc = p;
        return e;
    endfunction

    // Expected per-cycle outputs after the start edge: every pass walks lo..hi,
    // a triangle pass then walks hi..lo; the final entry is the done cycle.
    task automatic build(input int l, input int h, input int m, input int np);
        model_q.delete();
        for (int p = 0; p < np; p++) begin
            for (int v = l; v <= h; v++)
                model_q.push_back(mk(v, 1, (v != h) ? 1 : 0, 1, 0, p));
            if (m != 0)
                for (int v = h; v >= l; v--)
                    model_q.push_back(mk(v, 0, (v != l) ? 1 : 0, 1, 0, p));
        end
        model_q.push_back(mk((m != 0) ? l : h, 1, 0, 0, 1, np));
    endtask

    task automatic check_entry(input string tag, input exp_t e);
        check({tag, ".bin"},   int'(bin_count), e.bin);
        check({tag, ".ud"},    int'(up_down),   e.ud);
        check({tag, ".ce"},    int'(count_en),  e.ce);
        check({tag, ".busy"},  int'(busy),      e.busy);
        check({tag, ".done"},  int'(done),      e.done);
        check({tag, ".pc"},    int'(pass_cnt),  e.pc);
        check({tag, ".err"},   int'(err),       0);
    endtask

    // One sweep; abort_at / ign_at / rst_at select an entry index (-1 = unused).
    task automatic run_sweep(input string tag, input int l, input int h, input int m,
                             input int np, input int abort_at, input int ign_at,
                             input int rst_at);
        int cyc;
        build(l, h, m, np);
        cyc = 0;
        @(negedge clk);
        start = 1'b1; lo = 4'(l); hi = 4'(h); mode = m[0]; passes = 4'(np);
        for (int i = 0; i < model_q.size(); i++) begin
            @(negedge clk);
            cyc++;
            check_entry(tag, model_q[i]);
            if (i == 0) start = 1'b0;
            if (i == ign_at) begin
                start = 1'b1; lo = 4'd0; hi = 4'd15; mode = ~m[0]; passes = 4'd1;
            end else if (i == ign_at + 1) begin
                start = 1'b0;
            end
            if (i == rst_at) begin
                #2 rst = 1'b1;
                #1;
                check({tag, ".rst_bin"},  int'(bin_count), 0);
                check({tag, ".rst_busy"}, int'(busy),      0);
                check({tag, ".rst_ud"},   int'(up_down),   1);
                check({tag, ".rst_pc"},   int'(pass_cnt),  0);
                check({tag, ".rst_done"}, int'(done),      0);
                @(negedge clk);
                rst = 1'b0;
                exp_bin = 0; exp_pc = 0;
                $display("sweep %s lo=%0d hi=%0d mode=%0d passes=%0d reset at cycle %0d",
                         tag, l, h, m, np, cyc);
                return;
            end
            if (i == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check({tag, ".abt_busy"}, int'(busy),      0);
                check({tag, ".abt_done"}, int'(done),      0);
                check({tag, ".abt_bin"},  int'(bin_count), model_q[i].bin);
                check({tag, ".abt_pc"},   int'(pass_cnt),  model_q[i].pc);
                @(negedge clk);
                check({tag, ".abt_done2"}, int'(done), 0);
                check({tag, ".abt_busy2"}, int'(busy), 0);
                exp_bin = model_q[i].bin; exp_pc = model_q[i].pc;
                $display("sweep %s lo=%0d hi=%0d mode=%0d passes=%0d aborted at bin=%0d",
                         tag, l, h, m, np, exp_bin);
                return;
            end
        end
        exp_bin = model_q[model_q.size()-1].bin;
        exp_pc  = np;
        @(negedge clk);
        check({tag, ".idle_busy"}, int'(busy),      0);
        check({tag, ".idle_done"}, int'(done),      0);
        check({tag, ".idle_bin"},  int'(bin_count), exp_bin);
        check({tag, ".idle_pc"},   int'(pass_cnt),  exp_pc);
        check({tag, ".idle_ud"},   int'(up_down),   1);
        $display("sweep %s lo=%0d hi=%0d mode=%0d passes=%0d done after %0d edges",
                 tag, l, h, m, np, cyc);
    endtask

    task automatic reject(input string tag, input int l, input int h, input int np);
        @(negedge clk);
        start = 1'b1; lo = 4'(l); hi = 4'(h); passes = 4'(np); mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check({tag, ".err"},  int'(err),       1);
        check({tag, ".busy"}, int'(busy),      0);
        check({tag, ".bin"},  int'(bin_count), exp_bin);
        check({tag, ".pc"},   int'(pass_cnt),  exp_pc);
        @(negedge clk);
        check({tag, ".err_end"}, int'(err),  0);
        check({tag, ".busy2"},   int'(busy), 0);
        $display("reject %s lo=%0d hi=%0d passes=%0d", tag, l, h, np);
    endtask

    initial begin
        int rl, rh, rm, rp;
        @(negedge clk);
        check("reset.bin",  int'(bin_count), 0);
        check("reset.ud",   int'(up_down),   1);
        check("reset.ce",   int'(count_en),  0);
        check("reset.busy", int'(busy),      0);
        check("reset.done", int'(done),      0);
        check("reset.err",  int'(err),       0);
        check("reset.pc",   int'(pass_cnt),  0);
        rst = 1'b0;

        run_sweep("saw_2_5",   2, 5,  0, 2, -1, -1, -1);
        run_sweep("tri_2_4",   2, 4,  1, 1, -1, -1, -1);
        run_sweep("saw_full",  0, 15, 0, 1, -1, -1, -1);
        run_sweep("tri_full",  0, 15, 1, 1, -1, -1, -1);
        run_sweep("saw_eq",    7, 7,  0, 3, -1, -1, -1);
        run_sweep("tri_eq",    9, 9,  1, 2, -1, -1, -1);
        reject("rej_lohi", 9, 3, 2);
        reject("rej_pass0", 1, 4, 0);
        run_sweep("tri_abort", 1, 10, 1, 2, 5, -1, -1);
        run_sweep("after_abt", 3, 6,  0, 1, -1, -1, -1);
        run_sweep("tri_ign",   2, 8,  1, 2, -1, 4, -1);
        run_sweep("saw_rst",   0, 15, 0, 2, -1, -1, 7);
        run_sweep("after_rst", 4, 5,  1, 3, -1, -1, -1);

        for (int k = 0; k < 20; k++) begin
            rl = $urandom_range(0, 15);
            rh = $urandom_range(rl, 15);
            rm = $urandom_range(0, 1);
            rp = $urandom_range(1, 3);
            if ((k % 5) == 4) reject("rnd_rej", rh + 1 > 15 ? 15 : rh + 1, rl == 15 ? 14 : rl, rp);
            run_sweep("rnd", rl, rh, rm, rp, -1, -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
